// File: rtl/edge_frame_buffer_pp_if.sv
// Stream-in, reader-port and bank-ownership signals of the ping-pong edge frame buffer.
// The slave modport is the buffer; the master modport is the edge filter plus the blob detector.
interface edge_frame_buffer_pp_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_sof;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_wren;
  logic [DATA_WIDTH-1:0] rd_wdata;
  logic [DATA_WIDTH-1:0] rd_rdata;
  logic                  rd_rvalid;
  logic                  frame_ready;
  logic                  frame_release;
  logic                  wr_bank;
  logic                  rd_bank;

  modport slave (
    input  in_data, in_valid, in_sof,
    input  rd_en, rd_addr, rd_wren, rd_wdata, frame_release,
    output rd_rdata, rd_rvalid, frame_ready, wr_bank, rd_bank
  );

  modport master (
    output in_data, in_valid, in_sof,
    output rd_en, rd_addr, rd_wren, rd_wdata, frame_release,
    input  rd_rdata, rd_rvalid, frame_ready, wr_bank, rd_bank
  );
endinterface

// File: rtl/edge_frame_buffer_pp.sv
// Ping-pong frame store: writer fills one bank, reader owns the other; swap at frame end. EDGE_FB_STATS_EN adds frames_dropped.
// Latency: pixel committed at accepting edge; frame_ready 1 cycle after last pixel; read data 1 cycle after rd_en.
// Backpressure: none; a frame completing while the reader still holds its bank is dropped.
module edge_frame_buffer_pp #(
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  edge_frame_buffer_pp_if.slave  bus
`ifdef EDGE_FB_STATS_EN
  ,
  output logic [15:0]            frames_dropped
`endif
);

  localparam int N     = FRAME_W * FRAME_H;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]    LAST  = IDX_W'(N - 1);
  localparam logic [ADDR_WIDTH:0] N_EXT = (ADDR_WIDTH + 1)'(N);

  logic [DATA_WIDTH-1:0] mem0 [N];
  logic [DATA_WIDTH-1:0] mem1 [N];

  logic [IDX_W-1:0]      wr_ptr;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  wr_bank_q;
  logic                  rd_bank;
  logic                  ready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  addr_ok;
  logic                  rd_we;
  logic                  complete;
  logic                  eff_ready;

  // The two banks are always complementary, so one register carries ownership.
  assign rd_bank   = ~wr_bank_q;
  assign wr_idx    = bus.in_sof ? '0 : wr_ptr;
  assign rd_idx    = bus.rd_addr[IDX_W-1:0];
  assign addr_ok   = ({1'b0, bus.rd_addr} < N_EXT);
  assign rd_we     = bus.rd_en && bus.rd_wren && ready_q && addr_ok;
  assign complete  = bus.in_valid && !bus.in_sof && (wr_ptr == LAST);
  assign eff_ready = ready_q && !bus.frame_release;
  assign rd_word   = rd_bank ? mem1[rd_idx] : mem0[rd_idx];

  // Bank storage is not reset; writer and reader never target the same bank.
  always_ff @(posedge clock) begin
    if (bus.in_valid && !wr_bank_q) begin
      mem0[wr_idx] <= bus.in_data;
    end else if (rd_we && !rd_bank) begin
      mem0[rd_idx] <= bus.rd_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (bus.in_valid && wr_bank_q) begin
      mem1[wr_idx] <= bus.in_data;
    end else if (rd_we && rd_bank) begin
      mem1[rd_idx] <= bus.rd_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      wr_bank_q <= 1'b0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rdata_q <= addr_ok ? rd_word : '0;
      end

      if (bus.in_valid) begin
        if (bus.in_sof) begin
          wr_ptr <= IDX_W'(1);
        end else if (complete) begin
          wr_ptr <= '0;
        end else begin
          wr_ptr <= wr_ptr + IDX_W'(1);
        end
      end

      // A swap in the same cycle as a release keeps frame_ready high.
      if (complete && !eff_ready) begin
        wr_bank_q <= ~wr_bank_q;
        ready_q   <= 1'b1;
      end else if (bus.frame_release && ready_q) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign bus.rd_rdata    = rdata_q;
  assign bus.rd_rvalid   = rvalid_q;
  assign bus.frame_ready = ready_q;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.rd_bank     = rd_bank;

`ifdef EDGE_FB_STATS_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (complete && eff_ready && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign frames_dropped = drop_cnt;
`endif

endmodule

// File: tb/tb_edge_frame_buffer_pp.sv
// Bench for edge_frame_buffer_pp on a 4x2 frame: read results are scoreboarded, ownership checked directly.
module tb_edge_frame_buffer_pp;
  localparam int FW = 4;
  localparam int FH = 2;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   exp_q [$];
`ifdef EDGE_FB_STATS_EN
  logic [15:0] frames_dropped;
`endif

  edge_frame_buffer_pp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  edge_frame_buffer_pp #(
    .FRAME_W(FW), .FRAME_H(FH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef EDGE_FB_STATS_EN
    ,
    .frames_dropped(frames_dropped)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read results are compared against the scoreboard as they emerge.
  always @(negedge clock) begin
    if (!reset && bus.rd_rvalid) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 32'(bus.rd_rvalid), 32'd0);
      end else begin
        check("rd_rdata", 32'(bus.rd_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic pix(input logic [7:0] d, input logic sof);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = sof;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic stream(input int first, input int cnt, input logic sof);
    for (int i = 0; i < cnt; i++) pix(8'(first + i), sof && (i == 0));
  endtask

  task automatic rd_op(input int addr, input logic wren, input logic [7:0] wd, input int exp);
    bus.rd_en    = 1'b1;
    bus.rd_addr  = AW'(addr);
    bus.rd_wren  = wren;
    bus.rd_wdata = wd;
    exp_q.push_back(exp);
    @(posedge clock); #1;
    bus.rd_en   = 1'b0;
    bus.rd_wren = 1'b0;
  endtask

  task automatic read_seq(input int first_addr, input int cnt, input int first_val);
    for (int i = 0; i < cnt; i++) rd_op(first_addr + i, 1'b0, 8'h00, first_val + i);
  endtask

  task automatic release_frame();
    bus.frame_release = 1'b1;
    @(posedge clock); #1;
    bus.frame_release = 1'b0;
  endtask

  task automatic check_own(input string tag, input logic rdy, input logic rdb, input logic wrb);
    check({tag, "_frame_ready"}, 32'(bus.frame_ready), 32'(rdy));
    check({tag, "_rd_bank"},     32'(bus.rd_bank),     32'(rdb));
    check({tag, "_wr_bank"},     32'(bus.wr_bank),     32'(wrb));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_wren = 1'b0; bus.rd_wdata = '0;
    bus.frame_release = 1'b0;
    #3;
    check_own("reset", 1'b0, 1'b1, 1'b0);
    check("reset_rd_rvalid", 32'(bus.rd_rvalid), 32'd0);
    check("reset_rd_rdata",  32'(bus.rd_rdata),  32'd0);
`ifdef EDGE_FB_STATS_EN
    check("reset_dropped", 32'(frames_dropped), 32'd0);
`endif
    @(posedge clock); #1;
    reset = 1'b0;

    // First frame swaps in.
    stream(1, 7, 1'b1);
    check("f1_before_last_ready", 32'(bus.frame_ready), 32'd0);
    pix(8'd8, 1'b0);
    check_own("f1", 1'b1, 1'b0, 1'b1);
    read_seq(0, 8, 1);

    // Second frame with reader still holding: dropped.
    stream(11, 8, 1'b1);
    check_own("drop", 1'b1, 1'b0, 1'b1);
`ifdef EDGE_FB_STATS_EN
    check("drop_count", 32'(frames_dropped), 32'd1);
`endif
    read_seq(0, 8, 1);

    // Reader read-modify-write, then writes blocked once released.
    rd_op(3, 1'b1, 8'hAA, 4);
    rd_op(3, 1'b0, 8'h00, 8'hAA);
    release_frame();
    check("release_ready", 32'(bus.frame_ready), 32'd0);
    rd_op(5, 1'b1, 8'h55, 6);
    rd_op(5, 1'b0, 8'h00, 6);
    rd_op(3, 1'b0, 8'h00, 8'hAA);

    // Swap into bank 1, then release coinciding with the last pixel.
    stream(21, 8, 1'b1);
    check_own("f3", 1'b1, 1'b1, 1'b0);
    rd_op(0, 1'b0, 8'h00, 21);
    rd_op(7, 1'b0, 8'h00, 28);
    stream(31, 7, 1'b1);
    bus.frame_release = 1'b1;
    pix(8'd38, 1'b0);
    bus.frame_release = 1'b0;
    check_own("rel_swap", 1'b1, 1'b0, 1'b1);
`ifdef EDGE_FB_STATS_EN
    check("rel_swap_dropped", 32'(frames_dropped), 32'd1);
`endif
    rd_op(0, 1'b0, 8'h00, 31);
    rd_op(3, 1'b0, 8'h00, 34);

    // Mid-frame sof restarts the frame.
    release_frame();
    stream(41, 5, 1'b1);
    stream(51, 7, 1'b1);
    check("sof_abort_ready", 32'(bus.frame_ready), 32'd0);
    pix(8'd58, 1'b0);
    check_own("sof", 1'b1, 1'b1, 1'b0);
    read_seq(0, 8, 51);
    rd_op(8, 1'b1, 8'h77, 0);
    rd_op(0, 1'b0, 8'h00, 51);

    // Asynchronous reset while streaming with a frame held.
    stream(61, 3, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd64;
    bus.rd_en    = 1'b1;
    bus.rd_addr  = AW'(1);
    exp_q.push_back(52);
    @(posedge clock); #1;
    bus.rd_en   = 1'b0;
    bus.in_data = 8'd65;
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    check_own("arst", 1'b0, 1'b1, 1'b0);
    check("arst_rd_rvalid", 32'(bus.rd_rvalid), 32'd0);
    check("arst_rd_rdata",  32'(bus.rd_rdata),  32'd0);
`ifdef EDGE_FB_STATS_EN
    check("arst_dropped", 32'(frames_dropped), 32'd0);
`endif
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // No sof here: the frame must start from the reset pointer.
    stream(71, 7, 1'b0);
    check("post_rst_before_last", 32'(bus.frame_ready), 32'd0);
    pix(8'd78, 1'b0);
    check_own("post_rst", 1'b1, 1'b0, 1'b1);
    read_seq(0, 8, 71);

    repeat (3) begin
      @(posedge clock); #1;
    end
    check("scoreboard_pending", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
